// File: rtl/pipe_pkg.sv
// Shared widths and helpers for the elastic inter-stage pipeline register.
package pipe_pkg;
  localparam int PC_W       = 32;
  localparam int REGADDR_W  = 5;
  localparam int WORD_W     = 32;
  localparam int NUM_WORDS  = 5;
  localparam int DEF_PAYLOAD_W = NUM_WORDS * WORD_W + REGADDR_W;
  localparam int TNEW_MAX_W = 8;

  // Tnew counts down by one per stage and bottoms out at zero.
  function automatic logic [TNEW_MAX_W-1:0] sat_dec(input logic [TNEW_MAX_W-1:0] t);
    return (t == '0) ? '0 : t - 8'd1;
  endfunction
endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+data register slot; set wins over clear, write is independent.
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set_vld,
  input  logic         clr_vld,
  input  logic         wr,
  input  logic [W-1:0] d,
  output logic         vld_q,
  output logic [W-1:0] data_q
);
  logic         vld_d;
  logic [W-1:0] data_d;

  always_comb begin
    vld_d  = set_vld ? 1'b1 : (clr_vld ? 1'b0 : vld_q);
    data_d = wr ? d : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register carrying PC, decremented Tnew and an opaque payload,
// with optional 2-entry skid buffer and flush-to-bubble.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W        = DEF_PAYLOAD_W,
  parameter int TNEW_W           = 2,
  parameter int SKID             = 1,
  parameter int KEEP_PC_ON_FLUSH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic [PAYLOAD_W-1:0] out_payload
);
  localparam int DW = PC_W + TNEW_W + PAYLOAD_W;

  logic          main_v, skid_v;
  logic [DW-1:0] main_data, skid_data, in_data, bubble;
  logic          m_set, m_clr, m_wr, s_set, s_clr, s_wr;
  logic [DW-1:0] m_d, s_d;
  logic          in_xfer, out_xfer, main_free;
  logic [PC_W-1:0] bubble_pc;

  assign in_data  = {in_pc, TNEW_W'(sat_dec(TNEW_MAX_W'(in_tnew))), in_payload};
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_v & out_ready;
  assign main_free = ~main_v | out_ready;

  // Flushed bubble keeps a PC for exception reporting; an empty stage adopts the incoming PC.
  assign bubble_pc = !main_v ? in_pc
                   : (KEEP_PC_ON_FLUSH != 0) ? main_data[DW-1 -: PC_W] : '0;
  assign bubble    = {bubble_pc, {(TNEW_W + PAYLOAD_W){1'b0}}};

  always_comb begin
    m_set = 1'b0; m_clr = 1'b0; m_wr = 1'b0; m_d = in_data;
    s_set = 1'b0; s_clr = 1'b0; s_wr = 1'b0; s_d = in_data;
    if (flush) begin
      m_wr = 1'b1; m_clr = 1'b1; m_d = bubble;
      s_wr = 1'b1; s_clr = 1'b1; s_d = '0;
    end else if (SKID != 0) begin
      if (main_free) begin
        // Skid holds the older entry, so it always refills main first.
        if (skid_v) begin
          m_wr = 1'b1; m_set = 1'b1; m_d = skid_data; s_clr = 1'b1;
        end else if (in_xfer) begin
          m_wr = 1'b1; m_set = 1'b1;
        end else if (out_xfer) begin
          m_clr = 1'b1;
        end
      end else if (in_xfer) begin
        s_wr = 1'b1; s_set = 1'b1;
      end
    end else begin
      if (in_xfer) begin
        m_wr = 1'b1; m_set = 1'b1;
      end else if (out_xfer) begin
        m_clr = 1'b1;
      end
    end
  end

  pipe_skid_entry #(.W(DW)) u_main (
    .clk(clk), .reset(reset), .set_vld(m_set), .clr_vld(m_clr), .wr(m_wr),
    .d(m_d), .vld_q(main_v), .data_q(main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_entry #(.W(DW)) u_skid (
        .clk(clk), .reset(reset), .set_vld(s_set), .clr_vld(s_clr), .wr(s_wr),
        .d(s_d), .vld_q(skid_v), .data_q(skid_data)
      );
      assign in_ready = ~skid_v;
    end else begin : g_noskid
      assign skid_v    = 1'b0;
      assign skid_data = '0;
      assign in_ready  = out_ready | ~main_v;
    end
  endgenerate

  assign out_valid   = main_v;
  assign out_pc      = main_data[DW-1 -: PC_W];
  assign out_tnew    = main_data[PAYLOAD_W +: TNEW_W];
  assign out_payload = main_data[PAYLOAD_W-1:0];
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector bench for pipe_stage_reg: SKID=1 table plus SKID=0 and reset sequences.
module tb_pipe_stage_reg;
  localparam int PW = 165;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // SKID=1 instance
  logic a_rst, a_fl, a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_ipc, a_opc;
  logic [1:0]  a_it, a_ot;
  logic [PW-1:0] a_ip, a_op;
  // SKID=0 instance
  logic b_rst, b_fl, b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_ipc, b_opc;
  logic [1:0]  b_it, b_ot;
  logic [PW-1:0] b_ip, b_op;

  pipe_stage_reg #(.PAYLOAD_W(PW), .TNEW_W(2), .SKID(1), .KEEP_PC_ON_FLUSH(1)) u_a (
    .clk(clk), .reset(a_rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_pc(a_ipc), .in_tnew(a_it), .in_payload(a_ip), .out_valid(a_ov),
    .out_ready(a_or), .out_pc(a_opc), .out_tnew(a_ot), .out_payload(a_op));

  pipe_stage_reg #(.PAYLOAD_W(PW), .TNEW_W(2), .SKID(0), .KEEP_PC_ON_FLUSH(1)) u_b (
    .clk(clk), .reset(b_rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_pc(b_ipc), .in_tnew(b_it), .in_payload(b_ip), .out_valid(b_ov),
    .out_ready(b_or), .out_pc(b_opc), .out_tnew(b_ot), .out_payload(b_op));

  function automatic logic [PW-1:0] pay(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'h5a5a5a5a, pc + 32'd1, pc, pc[4:0]};
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // chk_mode: 0 = control only, 1 = data with payload derived from pc, 2 = data with zero payload
  typedef struct packed {
    logic        iv;
    logic [31:0] pc;
    logic [1:0]  t;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    logic [1:0]  et;
    logic        eir;
    logic [1:0]  mode;
  } vec_t;

  vec_t vecs[21];

  initial begin
    //            iv   pc           t    or   fl   ev   epc          et   ir   mode
    vecs[0]  = '{1'b1, 32'h3000, 2'd2, 1'b1, 1'b0, 1'b1, 32'h3000, 2'd1, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 32'h3004, 2'd1, 1'b1, 1'b0, 1'b1, 32'h3004, 2'd0, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, 32'h3008, 2'd0, 1'b1, 1'b0, 1'b1, 32'h3008, 2'd0, 1'b1, 2'd1};
    vecs[3]  = '{1'b0, 32'h0,    2'd0, 1'b1, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1, 2'd0};
    vecs[4]  = '{1'b1, 32'h3000, 2'd2, 1'b1, 1'b0, 1'b1, 32'h3000, 2'd1, 1'b1, 2'd1};
    vecs[5]  = '{1'b1, 32'h3004, 2'd1, 1'b0, 1'b0, 1'b1, 32'h3000, 2'd1, 1'b0, 2'd1};
    vecs[6]  = '{1'b1, 32'h3008, 2'd0, 1'b0, 1'b0, 1'b1, 32'h3000, 2'd1, 1'b0, 2'd1};
    vecs[7]  = '{1'b1, 32'h3008, 2'd0, 1'b0, 1'b0, 1'b1, 32'h3000, 2'd1, 1'b0, 2'd1};
    vecs[8]  = '{1'b1, 32'h3008, 2'd0, 1'b1, 1'b0, 1'b1, 32'h3004, 2'd0, 1'b1, 2'd1};
    vecs[9]  = '{1'b1, 32'h3008, 2'd0, 1'b1, 1'b0, 1'b1, 32'h3008, 2'd0, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 32'h0,    2'd0, 1'b1, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1, 2'd0};
    vecs[11] = '{1'b1, 32'h3010, 2'd3, 1'b0, 1'b0, 1'b1, 32'h3010, 2'd2, 1'b1, 2'd1};
    vecs[12] = '{1'b1, 32'h3014, 2'd1, 1'b0, 1'b0, 1'b1, 32'h3010, 2'd2, 1'b0, 2'd1};
    vecs[13] = '{1'b1, 32'h3018, 2'd1, 1'b0, 1'b1, 1'b0, 32'h3010, 2'd0, 1'b1, 2'd2};
    vecs[14] = '{1'b0, 32'h0,    2'd0, 1'b1, 1'b0, 1'b0, 32'h3010, 2'd0, 1'b1, 2'd2};
    vecs[15] = '{1'b1, 32'h301c, 2'd1, 1'b0, 1'b0, 1'b1, 32'h301c, 2'd0, 1'b1, 2'd1};
    vecs[16] = '{1'b1, 32'h3024, 2'd2, 1'b0, 1'b1, 1'b0, 32'h301c, 2'd0, 1'b1, 2'd2};
    vecs[17] = '{1'b0, 32'h0,    2'd0, 1'b1, 1'b0, 1'b0, 32'h301c, 2'd0, 1'b1, 2'd2};
    vecs[18] = '{1'b1, 32'h4000, 2'd0, 1'b1, 1'b0, 1'b1, 32'h4000, 2'd0, 1'b1, 2'd1};
    vecs[19] = '{1'b1, 32'h4004, 2'd3, 1'b1, 1'b0, 1'b1, 32'h4004, 2'd2, 1'b1, 2'd1};
    vecs[20] = '{1'b0, 32'h0,    2'd0, 1'b1, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1, 2'd0};

    a_rst = 1'b1; a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_ipc = '0; a_it = '0; a_ip = '0;
    b_rst = 1'b1; b_fl = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_ipc = '0; b_it = '0; b_ip = '0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    chk("a_rst_ov",  200'(a_ov),  200'(1'b0));
    chk("a_rst_pc",  200'(a_opc), 200'(32'h0));
    chk("a_rst_tn",  200'(a_ot),  200'(2'd0));
    chk("a_rst_pay", 200'(a_op),  200'(0));
    chk("a_rst_ir",  200'(a_ir),  200'(1'b1));
    chk("b_rst_ov",  200'(b_ov),  200'(1'b0));

    // Table: SKID=1 streaming, stall/skid ordering, flush, Tnew saturation
    for (int i = 0; i < 21; i++) begin
      a_iv = vecs[i].iv; a_ipc = vecs[i].pc; a_it = vecs[i].t; a_ip = pay(vecs[i].pc);
      a_or = vecs[i].ordy; a_fl = vecs[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ov", i), 200'(a_ov), 200'(vecs[i].ev));
      chk($sformatf("v%0d_ir", i), 200'(a_ir), 200'(vecs[i].eir));
      if (vecs[i].mode != 2'd0) begin
        chk($sformatf("v%0d_pc", i), 200'(a_opc), 200'(vecs[i].epc));
        chk($sformatf("v%0d_tn", i), 200'(a_ot), 200'(vecs[i].et));
        chk($sformatf("v%0d_pay", i), 200'(a_op),
            (vecs[i].mode == 2'd1) ? 200'(pay(vecs[i].epc)) : 200'(0));
      end
    end

    // Reset while stalled with the skid occupied
    a_fl = 1'b0; a_or = 1'b0;
    a_iv = 1'b1; a_ipc = 32'h5000; a_it = 2'd2; a_ip = pay(32'h5000);
    @(posedge clk); #1;
    a_ipc = 32'h5004; a_ip = pay(32'h5004);
    @(posedge clk); #1;
    chk("rs_skid_full_ir", 200'(a_ir), 200'(1'b0));
    a_rst = 1'b1; a_ipc = 32'h5008; a_ip = pay(32'h5008);
    @(posedge clk); #1;
    chk("rs_ov",  200'(a_ov),  200'(1'b0));
    chk("rs_pc",  200'(a_opc), 200'(32'h0));
    chk("rs_tn",  200'(a_ot),  200'(2'd0));
    chk("rs_pay", 200'(a_op),  200'(0));
    chk("rs_ir",  200'(a_ir),  200'(1'b1));
    a_rst = 1'b0; a_iv = 1'b0; a_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rs_noreplay%0d", k), 200'({a_ov, a_opc}), 200'({1'b0, 32'h0}));
    end

    // SKID=0: combinational in_ready and same-edge replacement
    b_iv = 1'b1; b_ipc = 32'h6000; b_it = 2'd1; b_ip = pay(32'h6000); b_or = 1'b0;
    #1;
    chk("b_ir_empty", 200'(b_ir), 200'(1'b1));
    @(posedge clk); #1;
    chk("b_load", 200'({b_ov, b_opc, b_ot}), 200'({1'b1, 32'h6000, 2'd0}));
    b_ipc = 32'h6004; b_it = 2'd2; b_ip = pay(32'h6004);
    #1;
    chk("b_ir_stall", 200'(b_ir), 200'(1'b0));
    @(posedge clk); #1;
    chk("b_hold", 200'({b_ov, b_opc, b_ot}), 200'({1'b1, 32'h6000, 2'd0}));
    chk("b_hold_pay", 200'(b_op), 200'(pay(32'h6000)));
    b_or = 1'b1;
    #1;
    chk("b_ir_comb", 200'(b_ir), 200'(1'b1));
    @(posedge clk); #1;
    chk("b_replace", 200'({b_ov, b_opc, b_ot}), 200'({1'b1, 32'h6004, 2'd1}));
    chk("b_replace_pay", 200'(b_op), 200'(pay(32'h6004)));
    b_fl = 1'b1; b_ipc = 32'h6008; b_or = 1'b0;
    @(posedge clk); #1;
    chk("b_flush", 200'({b_ov, b_opc, b_ot}), 200'({1'b0, 32'h6004, 2'd0}));
    chk("b_flush_pay", 200'(b_op), 200'(0));
    b_fl = 1'b0; b_iv = 1'b0;
    @(posedge clk); #1;
    chk("b_idle", 200'(b_ov), 200'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised inter-stage pipeline register that replaces the fixed-field EX/MEM-style latches with one reusable block. It carries an opaque payload, the instruction PC and a hazard Tnew counter. It adds a valid/ready elastic handshake with an optional 2-entry skid buffer, a flush input for bubble insertion, and saturating Tnew decrement on entry.
Instances sit between D/E, E/M and M/W; the hazard unit reads out_tnew.

Parameters:
PAYLOAD_W, 165, payload bits (Instruction, Result, WD, RegAddr, imm32, HILOout = 5*32+5).
TNEW_W, 2, width of the Tnew field.
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
KEEP_PC_ON_FLUSH, 1, 1 = the bubble created by flush keeps the PC of the flushed entry (for later EPC use); 0 = PC cleared to 0.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high; clears all state.
flush  in  1  kill stored entries and any incoming transfer this cycle.
in_valid  in  1  upstream has an entry.
in_ready  out  1  block can accept an entry.
in_pc  in  32  PC of the incoming entry.
in_tnew  in  TNEW_W  Tnew of the incoming entry, before decrement.
in_payload  in  PAYLOAD_W  opaque data.
out_valid  out  1  out_* holds a live entry.
out_ready  in  1  downstream accepts; deasserted = stall.
out_pc  out  32  PC of the held entry.
out_tnew  out  TNEW_W  decremented Tnew.
out_payload  out  PAYLOAD_W  data of the held entry.

Behaviour:
- Reset (highest priority): out_valid=0, out_pc=0, out_tnew=0, out_payload=0, skid entry invalid and zeroed.
  - SKID=1: in_ready=1 in the cycle after reset.
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - Latency is 1 cycle: an in_xfer at edge N appears on out_* after edge N when the main register is empty or drains that cycle.
- Tnew: stored value = (in_tnew==0) ? 0 : in_tnew-1. Saturating; never wraps.
- Payload and PC pass through unmodified.
- SKID=0 (single register):
  - in_ready = out_ready | ~out_valid (combinational).
  - On in_xfer: load the register and set out_valid=1.
  - On out_xfer without in_xfer: out_valid=0. Data may hold its stale value.
- SKID=1 (two entries: main and skid):
  - in_ready = ~skid_valid, registered; no combinational path from out_ready.
  - Main register empty or draining (out_xfer): incoming entry goes to main, or main refills from skid if skid is occupied. Order is preserved: the skid entry always leaves before a newer one.
  - Main register full and stalled (out_ready=0) with in_xfer: entry goes to skid; in_ready drops next cycle.
  - Both full, out_ready=1: main loads from skid, skid empties, in_ready=1 next cycle.
  - Full throughput: one entry per cycle with out_ready held at 1.
- Flush (priority below reset, above all transfers):
  - out_valid=0, skid_valid=0, out_tnew=0, out_payload=0.
  - out_pc keeps its current value if KEEP_PC_ON_FLUSH=1, else 0. If the main register was empty, out_pc takes in_pc instead.
  - A simultaneous in_xfer is discarded.
  - SKID=1: in_ready=1 next cycle.
- Stall with no input: all outputs hold bit-exact.
- Reset during a stall or with the skid occupied: all state is cleared; nothing is replayed.

Decomposition:
- Shared package pipe_pkg holds:
  - default widths (PC_W=32, REGADDR_W=5);
  - PAYLOAD_W computation constants;
  - a sat_dec function for Tnew.
- One natural sub-module: pipe_skid_entry, a single valid+data register with load and clear. Instantiate it twice when SKID=1, once when SKID=0.

Test Plan:
1. Reset then streaming, SKID=1, out_ready=1: in_pc=0x3000,0x3004,0x3008 with in_tnew=2,1,0 on consecutive cycles -> out_pc of the same values 1 cycle later; out_tnew=1,0,0; out_valid continuous; in_ready stays 1.
2. Stall: main holds 0x3000; drop out_ready for 3 cycles while offering 0x3004, 0x3008 -> 0x3004 goes to skid; in_ready=0 from the next cycle; 0x3008 is held upstream. Raise out_ready -> order out 0x3000, 0x3004, 0x3008 with no loss or duplication.
3. Flush with both entries full: out_pc=0x3010 -> next cycle out_valid=0, out_tnew=0, out_payload=0, out_pc=0x3010 (KEEP_PC_ON_FLUSH=1), in_ready=1; a concurrent in_pc=0x3018 never appears on out_*.
4. SKID=0 instance: hold out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> replacement occurs in the same edge; out_valid stays 1.
5. Reset mid-stall with skid occupied -> next cycle every output is 0 and out_valid=0; the old entries never reappear after reset falls.
6. Tnew saturation: in_tnew=0 -> out_tnew=0, no wrap to 3; in_tnew=3 -> out_tnew=2.
